door_ctl: RTL and testbench

DOOR_CTL -- requirements
Module: door_ctl

---
 rtl/door_ctl.sv | 223 ++++++++++++++++++++++
 tb/tb_door_ctl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/door_ctl.sv
// Frame-paced door controller: two players request the door, grants are round-robin.
// Build option DOOR_AUTO_CLOSE_EN enables the hold timer; without it a request toggles an open door.
module door_ctl #(
  parameter int unsigned DOOR_X_MIN  = 300,
  parameter int unsigned DOOR_X_MAX  = 400,
  parameter int unsigned DOOR_H      = 100,
  parameter int unsigned STEP        = 4,
  parameter int unsigned HOLD_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_tick,
  input  logic        btn_p1,
  input  logic        btn_p2,
  input  logic [11:0] xpos_p1,
  input  logic [11:0] xpos_p2,
  output logic [7:0]  door_height,
  output logic        door_open,
  output logic [1:0]  door_state,
  output logic [1:0]  owner
);

  localparam int unsigned XW = 12;
  localparam int unsigned HW = 9;
  localparam int unsigned OW = 8;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P1   = 2'd1;
  localparam logic [1:0] OWN_P2   = 2'd2;

  state_t          state_q;
  state_t          state_d;
  logic [OW-1:0]   height_q;
  logic [OW-1:0]   height_d;
  logic [1:0]      owner_q;
  logic [1:0]      owner_d;
  logic            door_open_q;

  logic            vt_d_q;
  logic [1:0]      btn_d_q;
  logic [1:0]      pend_q;
  logic            last_p2_q;

  logic            frame;
  logic [1:0]      btn_rise;
  logic [1:0]      req;
  logic            req_any;
  logic [1:0]      grant;
  logic            accept;
  logic            in_zone;
  logic            p1_in_zone;
  logic            p2_in_zone;
  logic [HW-1:0]   h_ext;
  logic [HW-1:0]   h_up;
  logic [HW-1:0]   h_up_sat;
  logic [HW-1:0]   h_dn;

`ifdef DOOR_AUTO_CLOSE_EN
  logic [OW-1:0]   hold_q;
  logic [OW-1:0]   hold_d;
  logic [OW-1:0]   hold_dec;
`endif

  // Edge detection: a frame is the rising edge of v_tick
  assign frame    = v_tick & ~vt_d_q;
  assign btn_rise = {btn_p2, btn_p1} & ~btn_d_q;
  // A button edge landing on the frame clock is folded into that frame
  assign req      = pend_q | btn_rise;
  assign req_any  = |req;

  assign p1_in_zone = (xpos_p1 >= XW'(DOOR_X_MIN)) && (xpos_p1 <= XW'(DOOR_X_MAX));
  assign p2_in_zone = (xpos_p2 >= XW'(DOOR_X_MIN)) && (xpos_p2 <= XW'(DOOR_X_MAX));
  assign in_zone    = p1_in_zone | p2_in_zone;

  // Saturating 9-bit height arithmetic
  assign h_ext    = HW'(height_q);
  assign h_up     = h_ext + HW'(STEP);
  assign h_up_sat = (h_up >= HW'(DOOR_H)) ? HW'(DOOR_H) : h_up;
  assign h_dn     = (h_ext <= HW'(STEP)) ? '0 : (h_ext - HW'(STEP));

  // Round-robin arbitration between simultaneous requests
  always_comb begin
    grant = OWN_NONE;
    case (req)
      2'b01:   grant = OWN_P1;
      2'b10:   grant = OWN_P2;
      2'b11:   grant = last_p2_q ? OWN_P1 : OWN_P2;
      default: grant = OWN_NONE;
    endcase
  end

`ifdef DOOR_AUTO_CLOSE_EN
  assign hold_dec = (hold_q == '0) ? '0 : (hold_q - OW'(1));
`endif

  // Next-state and datapath decode, evaluated once per frame
  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    owner_d  = owner_q;
    accept   = 1'b0;
`ifdef DOOR_AUTO_CLOSE_EN
    hold_d   = hold_q;
`endif

    case (state_q)
      CLOSED: begin
        if (req_any) begin
          accept   = 1'b1;
          state_d  = OPENING;
          height_d = OW'(h_up_sat);
        end
      end

      OPENING: begin
        height_d = OW'(h_up_sat);
        if (h_up_sat == HW'(DOOR_H)) begin
          state_d = OPEN;
`ifdef DOOR_AUTO_CLOSE_EN
          hold_d  = OW'(HOLD_FRAMES);
`endif
        end
      end

      OPEN: begin
`ifdef DOOR_AUTO_CLOSE_EN
        hold_d = hold_dec;
        if (req_any) begin
          accept = 1'b1;
          hold_d = OW'(HOLD_FRAMES);
        end else if ((hold_q == '0) && !in_zone) begin
          state_d  = CLOSING;
          height_d = OW'(h_dn);
        end
`else
        // Request toggles the door shut, but never onto a player in the doorway
        if (req_any && !in_zone) begin
          accept   = 1'b1;
          state_d  = CLOSING;
          height_d = OW'(h_dn);
        end
`endif
      end

      CLOSING: begin
        if (req_any || in_zone) begin
          accept   = req_any;
          state_d  = OPENING;
          height_d = OW'(h_up_sat);
        end else begin
          height_d = OW'(h_dn);
          if (h_dn == '0) begin
            state_d = CLOSED;
          end
        end
      end

      default: begin
        state_d  = CLOSED;
        height_d = '0;
      end
    endcase

    if (accept) begin
      owner_d = grant;
    end
  end

  // Input edge registers and pending flags run every clock
  always_ff @(posedge clk) begin
    if (rst) begin
      vt_d_q  <= 1'b0;
      btn_d_q <= 2'b00;
      pend_q  <= 2'b00;
    end else begin
      vt_d_q  <= v_tick;
      btn_d_q <= {btn_p2, btn_p1};
      pend_q  <= frame ? 2'b00 : (pend_q | btn_rise);
    end
  end

  // State and outputs advance only on a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLOSED;
      height_q    <= '0;
      owner_q     <= OWN_NONE;
      door_open_q <= 1'b0;
      last_p2_q   <= 1'b1;
    end else if (frame) begin
      state_q     <= state_d;
      height_q    <= height_d;
      owner_q     <= owner_d;
      door_open_q <= (state_d == OPEN);
      if (accept) begin
        last_p2_q <= (grant == OWN_P2);
      end
    end
  end

`ifdef DOOR_AUTO_CLOSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (frame) begin
      hold_q <= hold_d;
    end
  end
`endif

  assign door_height = height_q;
  assign door_open   = door_open_q;
  assign door_state  = state_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_door_ctl.sv
// Directed self-checking bench for door_ctl; expectations follow the build option DOOR_AUTO_CLOSE_EN.
module tb_door_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_tick;
  logic        btn_p1;
  logic        btn_p2;
  logic [11:0] xpos_p1;
  logic [11:0] xpos_p2;
  logic [7:0]  door_height;
  logic        door_open;
  logic [1:0]  door_state;
  logic [1:0]  owner;

  logic [12:0] obs;
  logic [12:0] exp_v;
  int          total = 0;
  int          bad   = 0;

  door_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .v_tick     (v_tick),
    .btn_p1     (btn_p1),
    .btn_p2     (btn_p2),
    .xpos_p1    (xpos_p1),
    .xpos_p2    (xpos_p2),
    .door_height(door_height),
    .door_open  (door_open),
    .door_state (door_state),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  assign obs = {door_state, door_height, door_open, owner};

  function automatic logic [12:0] pk(input logic [1:0] s, input logic [7:0] h,
                                     input logic o, input logic [1:0] w);
    return {s, h, o, w};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v_tick = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0;
    xpos_p1 = 12'd0; xpos_p2 = 12'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk);
    v_tick = 1'b1;
    @(negedge clk);
    v_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press(input logic b1, input logic b2);
    @(negedge clk);
    btn_p1 = b1; btn_p2 = b2;
    @(negedge clk);
    btn_p1 = 1'b0; btn_p2 = 1'b0;
  endtask

  // Drive an OPEN door into CLOSING by whatever means the build offers
  task automatic close_from_open();
`ifdef DOOR_AUTO_CLOSE_EN
    for (int i = 0; i < 200 && door_state != 2'd3; i++) frame();
    total++;
    if (door_state !== 2'd3) begin
      bad++; $display("FAIL close_timeout state got=%0d want=3", door_state);
    end
`else
    press(1'b1, 1'b0);
    frame();
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; v_tick = 1'b1; btn_p1 = 1'b1; btn_p2 = 1'b0;
    xpos_p1 = 12'd0; xpos_p2 = 12'd0;
    repeat (3) @(negedge clk);
    exp_v = pk(2'd0, 8'd0, 1'b0, 2'd0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, exp_v); end
    rst = 1'b0;
    @(negedge clk);
    v_tick = 1'b0; btn_p1 = 1'b0;
    exp_v = pk(2'd1, 8'd4, 1'b0, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_release_frame got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_open_ramp();
    do_reset();
    press(1'b1, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      frame();
      exp_v = pk((k < 25) ? 2'd1 : 2'd2, 8'(4 * k), (k == 25), 2'd1);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL ramp_frame%0d got=%h want=%h", k, obs, exp_v); end
      if (k == 10) begin
        repeat (6) @(negedge clk);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL hold_between_frames got=%h want=%h", obs, exp_v); end
      end
    end
  endtask

  task automatic test_hold_zone();
    xpos_p1 = 12'd350; xpos_p2 = 12'd0;
`ifdef DOOR_AUTO_CLOSE_EN
    frames(120);
    exp_v = pk(2'd2, 8'd100, 1'b1, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL hold_120 got=%h want=%h", obs, exp_v); end
    frame();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL hold0_in_zone got=%h want=%h", obs, exp_v); end
    xpos_p1 = 12'd300;
    frame();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL zone_min_edge got=%h want=%h", obs, exp_v); end
    xpos_p1 = 12'd0; xpos_p2 = 12'd400;
    frame();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL zone_max_edge got=%h want=%h", obs, exp_v); end
    xpos_p1 = 12'd299; xpos_p2 = 12'd401;
    frame();
    exp_v = pk(2'd3, 8'd96, 1'b0, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL leave_zone_close got=%h want=%h", obs, exp_v); end
`else
    frames(300);
    exp_v = pk(2'd2, 8'd100, 1'b1, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL persist_300 got=%h want=%h", obs, exp_v); end
    xpos_p1 = 12'd400;
    press(1'b1, 1'b0);
    frame();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL toggle_blocked_max got=%h want=%h", obs, exp_v); end
    xpos_p1 = 12'd0; xpos_p2 = 12'd300;
    press(1'b0, 1'b1);
    frame();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL toggle_blocked_min got=%h want=%h", obs, exp_v); end
    xpos_p1 = 12'd299; xpos_p2 = 12'd401;
    press(1'b0, 1'b1);
    frame();
    exp_v = pk(2'd3, 8'd96, 1'b0, 2'd2);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL toggle_close got=%h want=%h", obs, exp_v); end
`endif
    xpos_p1 = 12'd0; xpos_p2 = 12'd0;
  endtask

  task automatic test_reopen();
    logic [1:0] own_a;
    logic [1:0] own_b;
`ifdef DOOR_AUTO_CLOSE_EN
    own_a = 2'd1; own_b = 2'd2;
`else
    own_a = 2'd2; own_b = 2'd1;
`endif
    frames(9);
    exp_v = pk(2'd3, 8'd60, 1'b0, own_a);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL closing_60 got=%h want=%h", obs, exp_v); end
    press(1'b0, 1'b1);
    frame();
    exp_v = pk(2'd1, 8'd64, 1'b0, 2'd2);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reopen_req got=%h want=%h", obs, exp_v); end
    frames(9);
    exp_v = pk(2'd2, 8'd100, 1'b1, 2'd2);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reopen_full got=%h want=%h", obs, exp_v); end
    close_from_open();
    frame();
    exp_v = pk(2'd3, 8'd92, 1'b0, own_b);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL closing_92 got=%h want=%h", obs, exp_v); end
    xpos_p2 = 12'd400;
    frame();
    exp_v = pk(2'd1, 8'd96, 1'b0, own_b);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reopen_zone got=%h want=%h", obs, exp_v); end
    xpos_p2 = 12'd0;
  endtask

  task automatic test_round_robin();
    do_reset();
    press(1'b1, 1'b1);
    frame();
    exp_v = pk(2'd1, 8'd4, 1'b0, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rr_first got=%h want=%h", obs, exp_v); end
    press(1'b0, 1'b1);
    frame();
    exp_v = pk(2'd1, 8'd8, 1'b0, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL opening_ignores_req got=%h want=%h", obs, exp_v); end
    frames(23);
    frame();
    exp_v = pk(2'd2, 8'd100, 1'b1, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pending_cleared got=%h want=%h", obs, exp_v); end
    close_from_open();
    frames(24);
    exp_v = pk(2'd0, 8'd0, 1'b0, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL full_close got=%h want=%h", obs, exp_v); end
    frame();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL closed_idle got=%h want=%h", obs, exp_v); end
    press(1'b1, 1'b1);
    frame();
    exp_v = pk(2'd1, 8'd4, 1'b0, 2'd2);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rr_second got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    press(1'b1, 1'b0);
    frames(10);
    exp_v = pk(2'd1, 8'd40, 1'b0, 2'd1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pre_rst_40 got=%h want=%h", obs, exp_v); end
    rst = 1'b1; v_tick = 1'b1; btn_p2 = 1'b1;
    @(negedge clk);
    exp_v = pk(2'd0, 8'd0, 1'b0, 2'd0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rst_mid_opening got=%h want=%h", obs, exp_v); end
    rst = 1'b0; btn_p2 = 1'b0;
    @(negedge clk);
    v_tick = 1'b0;
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL post_rst_no_req got=%h want=%h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_open_ramp();
    test_hold_zone();
    test_reopen();
    test_round_robin();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
